// File: rtl/gecko_data_memory_responder_pkg.sv
// Shared Gecko load/store-path types used by the data-memory responder.
//   gecko_store_mask_t   : 4-bit byte write-enable mask, bit i enables byte lane i
//   gecko_mem_request_t  : one request {write, addr, mask, data}, 32-bit byte address
//   gecko_mem_response_t : one read response {data}
//   resp_state_e         : occupancy of the response buffer (output register + skid)
package gecko_data_memory_responder_pkg;

  localparam int GECKO_MEM_READ_LATENCY = 1;

  typedef logic [3:0] gecko_store_mask_t;

  typedef struct packed {
    logic              write;
    logic [31:0]       addr;
    gecko_store_mask_t mask;
    logic [31:0]       data;
  } gecko_mem_request_t;

  typedef struct packed {
    logic [31:0] data;
  } gecko_mem_response_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } resp_state_e;

endpackage

// File: rtl/gecko_data_memory_responder_if.sv
// Request/response bundle between the Gecko memory stage (master) and the
// data-memory responder (slave).
//   req_*  : valid/ready request stream (write, byte address, mask, data, tag)
//   resp_* : valid/ready read-response stream (data, tag)
// Optional macro GECKO_DATA_MEMORY_RESPONDER_ERROR_EN adds req_addr_hi (upper
// address bits), resp_error and the sticky write_error flag.
interface gecko_data_memory_responder_if
  import gecko_data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  gecko_store_mask_t     req_mask;
  logic [31:0]           req_data;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [TAG_WIDTH-1:0]  resp_tag;
`ifdef GECKO_DATA_MEMORY_RESPONDER_ERROR_EN
  logic [31-ADDR_WIDTH:0] req_addr_hi;
  logic                   resp_error;
  logic                   write_error;

  modport master (
    output req_valid, req_write, req_addr, req_mask, req_data, req_tag, req_addr_hi, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, resp_error, write_error
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_mask, req_data, req_tag, req_addr_hi, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, resp_error, write_error
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_mask, req_data, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_mask, req_data, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
`endif
endinterface

// File: rtl/gecko_byte_enable_ram.sv
// Single-port synchronous word RAM with four byte enables and a registered read.
//   clk, rst_n : clock, async active-low reset (read register only)
//   i_en       : access enable
//   i_we       : 1 = write lanes selected by i_be, 0 = read into o_rdata
//   i_be       : byte enables
//   i_addr     : word index
//   i_wdata    : write data
//   o_rdata    : read data, updated only by reads (writes leave it untouched)
module gecko_byte_enable_ram
  import gecko_data_memory_responder_pkg::*;
#(
  parameter int WORD_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_we,
  input  gecko_store_mask_t  i_be,
  input  logic [WORD_AW-1:0] i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata
);

  logic [31:0] r_mem [2**WORD_AW];
  logic [31:0] r_rdata;

  // NOTE: the array has no reset branch so it can map onto block RAM; only the
  // read register is reset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_rdata <= '0;
    else if (i_en && !i_we)  r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gecko_data_memory_responder.sv
// Gecko data-memory responder: byte-masked writes into a local word RAM and
// in-order, one-cycle-latency read responses with an output register plus a
// one-entry skid, so a stalled consumer never loses data.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of gecko_data_memory_responder_if (req_*/resp_*)
// Optional macro GECKO_DATA_MEMORY_RESPONDER_ERROR_EN: nonzero req_addr_hi makes
// reads return resp_error=1/resp_data=0 and blocks writes, setting write_error.
module gecko_data_memory_responder
  import gecko_data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 5
) (
  input logic clk,
  input logic rst_n,
  gecko_data_memory_responder_if.slave bus
);

  localparam int WORD_AW = ADDR_WIDTH - 2;

  typedef struct packed {
    gecko_mem_response_t  resp;
    logic [TAG_WIDTH-1:0] tag;
    logic                 err;
  } entry_t;

  resp_state_e          r_state, w_state_nxt;
  logic                 r_ready_en;
  // r_pend: the newest queued read still lives in the RAM read register and
  // must be copied into out/skid at the next edge.
  logic                 r_pend;
  logic [TAG_WIDTH-1:0] r_pend_tag;
  logic                 r_pend_err;
  logic                 r_write_error;
  entry_t               r_out, r_skid, w_out_nxt, w_skid_nxt;
  entry_t               w_pend, w_head, w_keep0, w_keep1;
  logic [1:0]           w_n_keep, w_count;
  gecko_mem_request_t   w_req;
  logic [31:0]          w_ram_q;
  logic                 w_req_fire, w_rd_fire, w_wr_fire, w_resp_fire, w_addr_err;
  logic                 w_unused;

  always_comb begin
    w_req.write = bus.req_write;
`ifdef GECKO_DATA_MEMORY_RESPONDER_ERROR_EN
    w_req.addr  = {bus.req_addr_hi, bus.req_addr};
`else
    w_req.addr  = {{(32-ADDR_WIDTH){1'b0}}, bus.req_addr};
`endif
    w_req.mask  = bus.req_mask;
    w_req.data  = bus.req_data;
  end

`ifdef GECKO_DATA_MEMORY_RESPONDER_ERROR_EN
  assign w_addr_err      = |w_req.addr[31:ADDR_WIDTH];
  assign bus.resp_error  = w_head.err;
  assign bus.write_error = r_write_error;
  assign w_unused        = ^w_req.addr[1:0];
`else
  assign w_addr_err = 1'b0;
  assign w_unused   = ^{w_req.addr[1:0], w_req.addr[31:ADDR_WIDTH], w_head.err, r_write_error};
`endif

  // Ready depends only on registers, never on resp_ready.
  assign bus.req_ready = r_ready_en && (r_state != ST_TWO);
  assign w_req_fire    = bus.req_valid && bus.req_ready;
  assign w_rd_fire     = w_req_fire && !w_req.write;
  assign w_wr_fire     = w_req_fire && w_req.write;

  gecko_byte_enable_ram #(.WORD_AW(WORD_AW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_rd_fire || (w_wr_fire && !w_addr_err)),
    .i_we    (w_req.write),
    .i_be    (w_req.mask),
    .i_addr  (w_req.addr[ADDR_WIDTH-1:2]),
    .i_wdata (w_req.data),
    .o_rdata (w_ram_q)
  );

  always_comb begin
    w_pend.resp.data = r_pend_err ? 32'd0 : w_ram_q;
    w_pend.tag       = r_pend_tag;
    w_pend.err       = r_pend_err;
    // A lone entry is the pending RAM read whenever r_pend is set.
    w_head = (r_state == ST_ONE && r_pend) ? w_pend : r_out;
  end

  assign bus.resp_valid = (r_state != ST_EMPTY);
  assign bus.resp_data  = w_head.resp.data;
  assign bus.resp_tag   = w_head.tag;
  assign w_resp_fire    = bus.resp_valid && bus.resp_ready;

  // Next-state: list the queued entries oldest first, drop the head on a
  // response handshake, keep the survivors in out/skid; a new read becomes
  // the pending RAM entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_keep0     = r_out;
    w_keep1     = r_skid;
    w_n_keep    = 2'd0;
    w_out_nxt   = r_out;
    w_skid_nxt  = r_skid;
    w_state_nxt = r_state;
    case (r_state)
      ST_ONE: begin
        w_keep0  = r_pend ? w_pend : r_out;
        w_n_keep = w_resp_fire ? 2'd0 : 2'd1;
      end
      ST_TWO: begin
        if (w_resp_fire) begin
          w_keep0  = r_pend ? w_pend : r_skid;
          w_n_keep = 2'd1;
        end else begin
          w_keep0  = r_out;
          w_keep1  = r_pend ? w_pend : r_skid;
          w_n_keep = 2'd2;
        end
      end
      default: w_n_keep = 2'd0;
    endcase
    if (w_n_keep != 2'd0) w_out_nxt  = w_keep0;
    if (w_n_keep == 2'd2) w_skid_nxt = w_keep1;
    w_count = w_n_keep + {1'b0, w_rd_fire};
    case (w_count)
      2'd0:    w_state_nxt = ST_EMPTY;
      2'd1:    w_state_nxt = ST_ONE;
      default: w_state_nxt = ST_TWO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_EMPTY;
      r_ready_en    <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_tag    <= '0;
      r_pend_err    <= 1'b0;
      r_out         <= '0;
      r_skid        <= '0;
      r_write_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready_en <= 1'b1;
      r_pend     <= w_rd_fire;
      r_out      <= w_out_nxt;
      r_skid     <= w_skid_nxt;
      if (w_rd_fire) begin
        r_pend_tag <= bus.req_tag;
        r_pend_err <= w_addr_err;
      end
      if (w_wr_fire && w_addr_err) r_write_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gecko_data_memory_responder.sv
// Directed self-checking bench for gecko_data_memory_responder.
module tb_gecko_data_memory_responder;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  gecko_data_memory_responder_if #(.ADDR_WIDTH(12), .TAG_WIDTH(5)) bus ();

  gecko_data_memory_responder #(.ADDR_WIDTH(12), .TAG_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [4:0] tag);
    int budget;
    budget        = 20;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_mask  = mask;
    bus.req_tag   = tag;
    while (!bus.req_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("req_accept", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [31:0] data, input logic [4:0] rtag);
    check({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    check({tag, "_data"}, bus.resp_data, data);
    check({tag, "_tag"}, {27'd0, bus.resp_tag}, {27'd0, rtag});
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_mask   = '0;
    bus.req_data   = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;
`ifdef GECKO_DATA_MEMORY_RESPONDER_ERROR_EN
    bus.req_addr_hi = '0;
`endif

    // Reset state
    tick(); tick();
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_resp_tag", {27'd0, bus.resp_tag}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
    tick();
    check("rel_req_ready_high", {31'd0, bus.req_ready}, 32'd1);

    // Full write then read: latency 1, data and tag
    send(1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 5'd0);
    send(1'b0, 12'h010, 32'h0, 4'b0000, 5'd3);
    pop("rd_full", 32'hDEADBEEF, 5'd3);
    check("empty_after_pop", {31'd0, bus.resp_valid}, 32'd0);

    // Partial write lane 1, mask-0 no-op write, read with low addr bits set
    send(1'b1, 12'h010, 32'h0000AA00, 4'b0010, 5'd0);
    send(1'b1, 12'h010, 32'hFFFFFFFF, 4'b0000, 5'd0);
    send(1'b0, 12'h013, 32'h0, 4'b0000, 5'd7);
    pop("rd_partial", 32'hDEADAAEF, 5'd7);

    // Last word and largest tag
    send(1'b1, 12'hFFC, 32'h12345678, 4'b1111, 5'd0);
    send(1'b1, 12'hFFC, 32'hA1B2C3D4, 4'b1001, 5'd0);
    send(1'b0, 12'hFFC, 32'h0, 4'b0000, 5'd31);
    pop("rd_last_word", 32'hA13456D4, 5'd31);

    // Back-to-back reads under backpressure
    send(1'b1, 12'h000, 32'h11111111, 4'b1111, 5'd0);
    send(1'b1, 12'h004, 32'h22222222, 4'b1111, 5'd0);
    send(1'b1, 12'h008, 32'h33333333, 4'b1111, 5'd0);
    send(1'b1, 12'h00C, 32'h44444444, 4'b1111, 5'd0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 12'h000;
    bus.req_tag   = 5'd0;
    tick();
    check("b2b_ready_after_1", {31'd0, bus.req_ready}, 32'd1);
    check("b2b_data_after_1", bus.resp_data, 32'h11111111);
    bus.req_addr = 12'h004;
    bus.req_tag  = 5'd1;
    tick();
    check("b2b_ready_after_2", {31'd0, bus.req_ready}, 32'd0);
    check("b2b_data_after_2", bus.resp_data, 32'h11111111);
    bus.req_addr = 12'h008;
    bus.req_tag  = 5'd2;
    tick();
    check("b2b_stall_ready", {31'd0, bus.req_ready}, 32'd0);
    check("b2b_stall_data", bus.resp_data, 32'h11111111);
    check("b2b_stall_tag", {27'd0, bus.resp_tag}, 32'd0);
    bus.resp_ready = 1'b1;
    tick();
    check("b2b_r1_data", bus.resp_data, 32'h22222222);
    check("b2b_r1_tag", {27'd0, bus.resp_tag}, 32'd1);
    check("b2b_r1_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    check("b2b_r2_valid", {31'd0, bus.resp_valid}, 32'd1);
    check("b2b_r2_data", bus.resp_data, 32'h33333333);
    check("b2b_r2_tag", {27'd0, bus.resp_tag}, 32'd2);
    bus.req_addr = 12'h00C;
    bus.req_tag  = 5'd3;
    tick();
    bus.req_valid = 1'b0;
    check("b2b_r3_data", bus.resp_data, 32'h44444444);
    check("b2b_r3_tag", {27'd0, bus.resp_tag}, 32'd3);
    tick();
    bus.resp_ready = 1'b0;
    check("b2b_drained", {31'd0, bus.resp_valid}, 32'd0);

    // Read, write same word next cycle, read again
    send(1'b0, 12'h000, 32'h0, 4'b0000, 5'd4);
    send(1'b1, 12'h000, 32'h55555555, 4'b1111, 5'd0);
    send(1'b0, 12'h000, 32'h0, 4'b0000, 5'd5);
    pop("raw_old", 32'h11111111, 5'd4);
    pop("raw_new", 32'h55555555, 5'd5);
    check("raw_drained", {31'd0, bus.resp_valid}, 32'd0);

    // Reset while two responses are held
    send(1'b0, 12'h004, 32'h0, 4'b0000, 5'd1);
    send(1'b0, 12'h008, 32'h0, 4'b0000, 5'd2);
    check("two_ready_low", {31'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_empty", {31'd0, bus.resp_valid}, 32'd0);
    send(1'b0, 12'h010, 32'h0, 4'b0000, 5'd9);
    pop("post_rst_rd0", 32'hDEADAAEF, 5'd9);
    send(1'b0, 12'h000, 32'h0, 4'b0000, 5'd10);
    pop("post_rst_rd1", 32'h55555555, 5'd10);

`ifdef GECKO_DATA_MEMORY_RESPONDER_ERROR_EN
    check("err_write_error_clear", {31'd0, bus.write_error}, 32'd0);
    bus.req_addr_hi = 20'd1;
    send(1'b0, 12'h010, 32'h0, 4'b0000, 5'd12);
    check("err_rd_flag", {31'd0, bus.resp_error}, 32'd1);
    pop("err_rd", 32'h00000000, 5'd12);
    send(1'b1, 12'h010, 32'h0BADF00D, 4'b1111, 5'd0);
    bus.req_addr_hi = 20'd0;
    check("err_write_error_set", {31'd0, bus.write_error}, 32'd1);
    send(1'b0, 12'h010, 32'h0, 4'b0000, 5'd13);
    check("err_rb_flag", {31'd0, bus.resp_error}, 32'd0);
    pop("err_readback", 32'hDEADAAEF, 5'd13);
    check("err_write_error_sticky", {31'd0, bus.write_error}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gecko_data_memory_responder.md
Name: gecko_data_memory_responder

Overview:
- Memory-side responder for the Gecko load/store path: the other end of the store-result (value/mask) and load-result path.
- Accepts word-aligned read/write requests on a valid/ready stream and applies byte-masked writes to an internal word array.
- Returns read data on a valid/ready response stream with registered, in-order, backpressure-safe delivery.
- Sits between the Gecko execute/memory stage and a local data RAM; used as the default data memory in simulation and on FPGA.

Parameters:
- ADDR_WIDTH, 12: byte-address width. Word depth = 2**(ADDR_WIDTH-2).
- TAG_WIDTH, 5: opaque request tag echoed on responses; the core carries rd_addr here.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request valid
- req_ready  output  1  request ready
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored
- req_mask  input  4  byte write enables (gecko_store_mask_t); ignored for reads
- req_data  input  32  write data, already lane-replicated
- req_tag  input  TAG_WIDTH  echoed on read response
- resp_valid  output  1  read response valid
- resp_ready  input  1  read response ready
- resp_data  output  32  raw 32-bit word read
- resp_tag  output  TAG_WIDTH  tag of the originating read

Behaviour:
- Reset: asynchronous, active-low on rst_n, with clk as the single clock.
  - resp_valid=0, resp_data=0, resp_tag=0, internal state EMPTY.
  - req_ready=1 one cycle after rst_n deasserts; it is 0 while in reset.
  - Array contents are not reset.
  - Reset mid-operation drops any held or pending responses; writes already accepted remain in the array.
- Transfer rule: a transfer occurs on valid && ready at a clk edge; req and resp are independent streams.
- Word index: req_addr[ADDR_WIDTH-1:2].
- Writes:
  - On accept, byte lane i is updated iff req_mask[i].
  - req_mask=0 is a legal no-op write.
  - Writes produce no response.
  - A write is visible to any read accepted in a later cycle.
- Reads:
  - Latency is exactly 1: a read accepted in cycle N presents resp_valid in cycle N+1 when the output slot is free.
  - Responses are strictly in request order.
- Response buffering, state machine EMPTY / ONE / TWO (output register plus one-entry skid):
  - EMPTY: read accept -> ONE.
  - ONE:
    - read accept without resp handshake -> TWO (new data into skid);
    - resp handshake without read -> EMPTY;
    - both -> ONE (new data into output register).
  - TWO:
    - resp handshake -> ONE (skid moves to output register);
    - no read accepted, because req_ready=0.
- req_ready = (state != TWO). It is registered-derived and has no combinational path from resp_ready.
- Writes are also gated by req_ready.
- Stability: resp_data and resp_tag stay stable while resp_valid && !resp_ready.
- Sustained throughput: one read per cycle when resp_ready=1.
- Address wrap: addresses beyond the depth alias modulo depth; this is not an error unless the optional feature is enabled.

Optional Feature:
- Macro: GECKO_DATA_MEMORY_RESPONDER_ERROR_EN.
- When defined:
  - Extra output resp_error (1) and sticky output write_error (1, cleared only by reset).
  - Address bits above ADDR_WIDTH are supplied on extra input req_addr_hi (32-ADDR_WIDTH bits).
  - Any nonzero req_addr_hi:
    - on a read -> response returned with resp_data=0, resp_error=1;
    - on a write -> array untouched, write_error set.
- When undefined: these ports are absent and addresses alias as above.

Decomposition:
- Shared gecko package, new entries:
  - typedef gecko_mem_request_t {write, addr, mask, data};
  - typedef gecko_mem_response_t {data};
  - parameter GECKO_MEM_READ_LATENCY = 1.
- Reuse the existing gecko_store_mask_t.
- One sub-module: gecko_byte_enable_ram, a single-port synchronous RAM with 4 byte enables and registered read. The responder holds the skid/FSM logic.

Test Plan:
- Write 0xDEADBEEF mask 4'b1111 to addr 0x010, then read 0x010 with tag 3 -> resp_valid next cycle, resp_data=0xDEADBEEF, resp_tag=3.
- Write 0x0000AA00 mask 4'b0010 to 0x010, then read 0x010 -> resp_data=0xDEADAAEF; mask 0 write leaves word unchanged.
- Back-to-back reads of 0x000, 0x004, 0x008, 0x00C with resp_ready held 0 -> req_ready drops after the 2nd accept. Then release resp_ready -> four responses in order, one per cycle, data never changes while stalled.
- Read 0x000 then write 0x000 next cycle then read 0x000 -> first response is the old value, second is the new value.
- Assert rst_n=0 while in TWO -> resp_valid=0 immediately. After release a read of the previously written address returns the written data.
- ERROR_EN build: read with req_addr_hi=1 -> resp_error=1, resp_data=0. Write with req_addr_hi=1 -> write_error=1, and a target-word read-back is unchanged.
